crc_job_sequencer: RTL and testbench

//  Upstream feeder and result collector for the serial CRC engine (crc core with control/enable/done).

---
 rtl/crc_job_sequencer_if.sv | 34 +++
 rtl/crc_job_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_crc_job_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_job_sequencer_if.sv
// Stream bundle around the CRC job sequencer: input words in, {data, crc} pairs out.
// slave is the sequencer's view; master is the producer/consumer side.
interface crc_job_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 3
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CRC_WIDTH-1:0]  out_crc;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_crc
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_crc
    );
endinterface

// File: rtl/crc_job_sequencer.sv
// Word FIFO feeding the serial CRC engine as load+compute jobs; results leave on a valid/ready port.
// Word-to-result latency DATA_WIDTH+4 cycles; in_ready depends only on FIFO occupancy, not on the FSM.
module crc_job_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointer wrap is the natural binary overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module crc_job_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    crc_job_sequencer_if.slave    bus,
    output logic                  busy,
    output logic                  err,
    output logic                  eng_enable,
    output logic                  eng_control,
    output logic [DATA_WIDTH-1:0] eng_data,
    input  logic [DATA_WIDTH-1:0] eng_result,
    input  logic                  eng_done
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] job_q, job_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CRC_WIDTH-1:0]  out_crc_q, out_crc_d;
    logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
    logic                  err_q, err_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  out_valid;
    logic                  unused_result_hi;

    // Only the low CRC_WIDTH bits of the engine result carry the CRC.
    assign unused_result_hi = ^eng_result[DATA_WIDTH-1:CRC_WIDTH];

    crc_job_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (bus.in_valid),
        .push_dat (bus.in_data),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!fifo_empty) state_d = S_LOAD;
            S_LOAD:    state_d = S_COMPUTE;
            // DATA_WIDTH shift cycles plus one more so the engine's done can register.
            S_COMPUTE: if (cyc_cnt_q == CNT_LAST) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_OUTPUT;
            S_OUTPUT:  if (bus.out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = 1'b0;
        eng_enable  = 1'b0;
        eng_control = 1'b0;
        eng_data    = '0;
        out_valid   = 1'b0;
        case (state_q)
            S_IDLE:    fifo_pop = ~fifo_empty;
            S_LOAD: begin
                eng_enable = 1'b1;
                eng_data   = job_q;
            end
            S_COMPUTE, S_CAPTURE: begin
                eng_control = 1'b1;
                eng_data    = job_q;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                eng_data  = job_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        job_d      = job_q;
        cyc_cnt_d  = cyc_cnt_q;
        out_data_d = out_data_q;
        out_crc_d  = out_crc_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE:    if (fifo_pop) job_d = fifo_head;
            S_LOAD:    cyc_cnt_d = '0;
            S_COMPUTE: cyc_cnt_d = cyc_cnt_q + 1'b1;
            S_CAPTURE: begin
                out_crc_d  = eng_result[CRC_WIDTH-1:0];
                out_data_d = job_q;
                // The engine should have finished by now; flag it permanently if not.
                if (!eng_done) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_q      <= '0;
            cyc_cnt_q  <= '0;
            out_data_q <= '0;
            out_crc_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            job_q      <= job_d;
            cyc_cnt_q  <= cyc_cnt_d;
            out_data_q <= out_data_d;
            out_crc_q  <= out_crc_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_crc   = out_crc_q;
    assign busy          = (state_q != S_IDLE) | ~fifo_empty;
    assign err           = err_q;
endmodule

// File: tb/tb_crc_job_sequencer.sv
// Bench for crc_job_sequencer: behavioural engine stand-in, known-CRC table, queue scoreboard,
// FIFO fill/backpressure, engine-not-done error and mid-job reset sequences.
module tb_crc_job_sequencer;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          busy, err, eng_enable, eng_control, eng_done;
    logic [DW-1:0] eng_data;
    logic [DW-1:0] eng_result;
    logic          force_done_low;

    logic [DW-1:0] mock_pending;
    logic [5:0]    mock_cnt;
    logic          mock_done;

    int            tests    = 0;
    int            fails    = 0;
    int            cyc      = 0;
    int            rx_count = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_data [256];
    int            rx_cyc  [256];

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] crc;
    } vec_t;
    vec_t vecs [7];

    crc_job_sequencer_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) bus ();

    crc_job_sequencer #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (CW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .err         (err),
        .eng_enable  (eng_enable),
        .eng_control (eng_control),
        .eng_data    (eng_data),
        .eng_result  (eng_result),
        .eng_done    (eng_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Polynomial long division of data(x)*x^3 by x^3+x+1.
    function automatic logic [CW-1:0] crc_of(input logic [DW-1:0] d);
        logic [DW+CW-1:0] r;
        r = {d, 3'b000};
        for (int i = DW + CW - 1; i >= CW; i--) begin
            if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
        end
        return r[CW-1:0];
    endfunction

    // Engine stand-in: done after DATA_WIDTH compute cycles, sticky until reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mock_pending <= '0;
            mock_cnt     <= '0;
            mock_done    <= 1'b0;
            eng_result   <= '0;
        end else if (eng_enable && !eng_control) begin
            mock_pending <= eng_data;
            mock_cnt     <= '0;
        end else if (eng_control) begin
            if (mock_cnt < 6'd32) mock_cnt <= mock_cnt + 6'd1;
            if (mock_cnt == 6'd31) begin
                mock_done  <= 1'b1;
                eng_result <= {~mock_pending[DW-1:CW], crc_of(mock_pending)};
            end
        end
    end
    assign eng_done = mock_done && !force_done_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                exp_q.delete();
            end else begin
                if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
                if (bus.out_valid && bus.out_ready) begin
                    check("sb_result_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_data", bus.out_data, e);
                        check("sb_crc", bus.out_crc, crc_of(e));
                    end
                    if (rx_count < 256) begin
                        rx_data[rx_count] = bus.out_data;
                        rx_cyc[rx_count]  = cyc;
                    end
                    rx_count++;
                end
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic complete();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, {bus.in_ready, bus.out_valid, busy, err, eng_enable, eng_control}, 6'b100000);
        check({tag, "_eng_data"}, eng_data, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_crc"}, bus.out_crc, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1);
    end

    initial begin
        int            n;
        int            base;
        logic [DW-1:0] fw [5];

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        force_done_low = 1'b0;
        vecs[0] = '{32'h0000_0001, 3'b011};
        vecs[1] = '{32'h0000_0000, 3'b000};
        vecs[2] = '{32'h0000_0010, 3'b001};
        vecs[3] = '{32'h8000_0000, 3'b101};
        vecs[4] = '{32'h0000_0002, 3'b110};
        vecs[5] = '{32'h0000_0004, 3'b111};
        vecs[6] = '{32'h0000_0003, 3'b101};
        fork
            monitor();
        join_none

        repeat (3) step();
        check_reset_values("in_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_flags", {bus.in_ready, bus.out_valid, eng_control, busy, err}, 5'b10000);
        end

        // Known-CRC table, each job started from an idle sequencer.
        for (int v = 0; v < 7; v++) begin
            send_word(vecs[v].data);
            wait_out_valid(n);
            check("vec_latency", n, 36);
            check("vec_out_data", bus.out_data, vecs[v].data);
            check("vec_out_crc", bus.out_crc, vecs[v].crc);
            check("vec_err", err, 0);
            complete();
            step();
        end

        // Fill: one word in the engine plus four queued makes the FIFO full.
        for (int i = 0; i < 5; i++) fw[i] = 32'hA5A5_0000 + 32'(i * 17);
        for (int i = 0; i < 5; i++) begin
            send_word(fw[i]);
            check("fill_in_ready", bus.in_ready, (i < 4) ? 1 : 0);
        end
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        step();
        step();
        check("full_push_ignored_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        base = rx_count;
        bus.out_ready = 1'b1;
        n = 0;
        while (rx_count < base + 5 && n < 1000) begin
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        check("fill_result_count", rx_count - base, 5);
        for (int i = 0; i < 5; i++) check("fill_order", rx_data[base + i], fw[i]);
        for (int i = 1; i < 5; i++) check("fill_job_spacing", rx_cyc[base + i] - rx_cyc[base + i - 1], 37);
        step();
        check("fill_drained", {exp_q.size() == 0, busy, bus.out_valid}, 3'b100);

        // Random traffic against the scoreboard.
        base = rx_count;
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) == 0);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        check("random_drain_pending", exp_q.size(), 0);
        check("random_drain_busy", busy, 0);
        check("random_err", err, 0);
        check("random_results_seen", rx_count - base > 10, 1);

        // Engine never reports done: err latches but results still flow.
        force_done_low = 1'b1;
        send_word(32'h0000_0010);
        wait_out_valid(n);
        check("nodone_latency", n, 36);
        check("nodone_err", err, 1);
        check("nodone_crc", bus.out_crc, 3'b001);
        complete();
        force_done_low = 1'b0;
        step();
        send_word(32'h0000_0001);
        wait_out_valid(n);
        check("err_sticky", err, 1);
        check("err_sticky_crc", bus.out_crc, 3'b011);
        complete();
        step();

        // Reset in the middle of COMPUTE with a second word queued.
        bus.in_data  = 32'h8000_0000;
        bus.in_valid = 1'b1;
        step();
        bus.in_data  = 32'h1234_5678;
        step();
        bus.in_valid = 1'b0;
        repeat (11) step();
        check("pre_reset_compute", {eng_control, busy}, 2'b11);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_job_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_flushed", {busy, bus.out_valid, err}, 3'b000);
        end
        send_word(32'h0000_0001);
        wait_out_valid(n);
        check("post_reset_latency", n, 36);
        check("post_reset_data", bus.out_data, 32'h0000_0001);
        check("post_reset_crc", bus.out_crc, 3'b011);
        check("post_reset_err", err, 0);
        complete();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
